// File: rtl/mem_arbiter_pkg.sv
// Shared rv32i types used by the memory arbiter: the FSM state encoding and the
// identifier of the port that currently owns the downstream memory port.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } mem_arb_owner_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational grant selection between the fetch and LSQ ports.
// Round-robin on contention when MEM_ARB_ROUND_ROBIN_EN is defined, LSQ-first otherwise.
module mem_arb_priority
  import rv32i_types::*;
(
  input  logic i_pend,
  input  logic d_pend,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_owner
);

  assign grant_valid = i_pend | d_pend;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // A contested grant goes to whichever port did not win the previous grant.
  always_comb begin
    grant_owner = ARB_D;
    if (i_pend && !d_pend) begin
      grant_owner = ARB_I;
    end else if (i_pend && d_pend && (last_grant == ARB_D)) begin
      grant_owner = ARB_I;
    end
  end
`else
  logic unusedLastGrant;
  assign unusedLastGrant = last_grant;

  assign grant_owner = (i_pend && !d_pend) ? ARB_I : ARB_D;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises the fetch and LSQ memory ports onto one registered downstream port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed LSQ priority.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [width/8-1:0]   i_mem_byte_enable,
  input  logic [width-1:0]     i_mem_address,
  input  logic [width-1:0]     i_mem_wdata,
  output logic                 i_mem_resp,
  output logic [width-1:0]     i_mem_rdata,

  input  logic                 lsq_mem_read,
  input  logic                 lsq_mem_write,
  input  logic [width/8-1:0]   lsq_mem_byte_enable,
  input  logic [width-1:0]     lsq_mem_address,
  input  logic [width-1:0]     lsq_mem_wdata,
  output logic                 lsq_mem_resp,
  output logic [width-1:0]     lsq_mem_rdata,

  output logic                 mem_read,
  output logic                 mem_write,
  output logic [width/8-1:0]   mem_byte_enable,
  output logic [width-1:0]     mem_address,
  output logic [width-1:0]     mem_wdata,
  input  logic                 mem_resp,
  input  logic [width-1:0]     mem_rdata
);

  mem_arb_state_t      state_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [width/8-1:0]  mem_byte_enable_q;
  logic [width-1:0]    mem_address_q;
  logic [width-1:0]    mem_wdata_q;

  logic i_pend;
  logic d_pend;
  logic grant_valid;
  logic grant_owner;
  logic last_grant;

  assign i_pend = i_mem_read | i_mem_write;
  assign d_pend = lsq_mem_read | lsq_mem_write;

  mem_arb_priority u_priority (
    .i_pend      (i_pend),
    .d_pend      (d_pend),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= ARB_D;
    end else if ((state_q == IDLE) && grant_valid) begin
      last_grant_q <= grant_owner;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = ARB_D;
`endif

  // Winner's request fields; a simultaneous read+write issues only the write.
  logic                sel_i;
  logic                sel_write;
  logic                sel_read;
  logic [width/8-1:0]  sel_byte_enable;
  logic [width-1:0]    sel_address;
  logic [width-1:0]    sel_wdata;

  assign sel_i           = (grant_owner == ARB_I);
  assign sel_write       = sel_i ? i_mem_write : lsq_mem_write;
  assign sel_read        = (sel_i ? i_mem_read : lsq_mem_read) & ~sel_write;
  assign sel_byte_enable = sel_i ? i_mem_byte_enable : lsq_mem_byte_enable;
  assign sel_address     = sel_i ? i_mem_address : lsq_mem_address;
  assign sel_wdata       = sel_i ? i_mem_wdata : lsq_mem_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_byte_enable_q <= '0;
      mem_address_q     <= '0;
      mem_wdata_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_q           <= sel_i ? SERVE_I : SERVE_D;
            mem_read_q        <= sel_read;
            mem_write_q       <= sel_write;
            mem_byte_enable_q <= sel_byte_enable;
            mem_address_q     <= sel_address;
            mem_wdata_q       <= sel_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_byte_enable_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;

  assign i_mem_resp    = (state_q == SERVE_I) & mem_resp;
  assign i_mem_rdata   = (state_q == SERVE_I) ? mem_rdata : '0;
  assign lsq_mem_resp  = (state_q == SERVE_D) & mem_resp;
  assign lsq_mem_rdata = (state_q == SERVE_D) ? mem_rdata : '0;

  rwConflict: assert property (@(posedge clk) disable iff (!rst)
    !(i_mem_read && i_mem_write) && !(lsq_mem_read && lsq_mem_write));

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter placed directly downstream of `cpu`. It accepts the instruction-fetch port (`i_mem_*`) and the load/store-queue port (`lsq_mem_*`) and serialises them onto a single word-wide memory/cache port. It grants one requester at a time, registers the granted request, and routes the response back to the owner.

## Interface
Parameters:
- `width`, 32, data/address width; byte enable is `width/8`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_mem_read`  in  1  fetch read request.
- `i_mem_write`  in  1  fetch write request.
- `i_mem_byte_enable`  in  width/8  fetch byte enable.
- `i_mem_address`  in  width  fetch address.
- `i_mem_wdata`  in  width  fetch write data.
- `i_mem_resp`  out  1  fetch response.
- `i_mem_rdata`  out  width  fetch read data.
- `lsq_mem_read`, `lsq_mem_write`, `lsq_mem_byte_enable`, `lsq_mem_address`, `lsq_mem_wdata`  in  same widths as the fetch-port inputs  LSQ request.
- `lsq_mem_resp`  out  1  LSQ response.
- `lsq_mem_rdata`  out  width  LSQ read data.
- `mem_read`  out  1  downstream read.
- `mem_write`  out  1  downstream write.
- `mem_byte_enable`  out  width/8  downstream byte enable.
- `mem_address`  out  width  downstream address.
- `mem_wdata`  out  width  downstream write data.
- `mem_resp`  in  1  downstream response.
- `mem_rdata`  in  width  downstream read data.

## Operation
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`.
- A requester is pending when its `read | write` is high.
- `IDLE` with no requester pending: the FSM stays in `IDLE`.
- `IDLE` with exactly one requester pending: the FSM grants it.
- `IDLE` with both requesters pending: the priority rule applies (see Configuration).
- On grant, the arbiter latches `read`, `write`, `byte_enable`, `address` and `wdata` from the winner into output registers. It then enters `SERVE_I` or `SERVE_D`.
- Downstream outputs are register-driven. They stay stable for the whole transaction and ignore later changes on the requester inputs.
- In `SERVE_x`: `x_mem_resp = mem_resp` (combinational) and `x_mem_rdata = mem_rdata`.
  - The non-owner sees `resp = 0`.
  - The non-owner sees `rdata = 0`.
- `mem_resp` in `SERVE_x`: the FSM goes to `IDLE` next cycle, with `mem_read` and `mem_write` cleared.
- Requester contract: hold the request until the cycle of its `resp`, then deassert it the following cycle.
- The arbiter never grants during `SERVE_x`. Requests raised meanwhile wait in their port.
- A requester with both `read` and `write` high: the write is issued and the read is dropped. A simulation assertion fires.
- `mem_resp` in `IDLE` is ignored. Both `x_mem_resp` outputs stay 0.

## Timing
- Reset (asynchronous, `rst` low): FSM goes to `IDLE` and the priority pointer resets to LSQ.
  - All downstream outputs go to 0: `mem_read`, `mem_write`, `mem_byte_enable`, `mem_address`, `mem_wdata`.
  - `i_mem_resp`, `lsq_mem_resp` and both `rdata` outputs go to 0.
- Reset mid-transaction abandons the transaction. No response is delivered.
- Request latency:
  - A request seen in `IDLE` at edge N produces `mem_read`/`mem_write` high from N+1.
  - Response in cycle M reaches the owner in cycle M (zero added latency).
- Back-to-back throughput: after the response cycle, at least one `IDLE` cycle follows.
  - The minimum transaction period is 1 grant cycle, the memory latency, and 1 idle cycle.
- A request that arrives in the same cycle as the other port's `mem_resp` waits until the following `IDLE` cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - When both ports are pending in `IDLE`, the port not granted last wins.
  - A 1-bit `last_grant` register is updated on every grant and resets to LSQ (the first contested grant goes to fetch).
- `MEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the LSQ always wins a contested grant.
  - No `last_grant` register exists.
  - Fetch can starve under continuous LSQ traffic; this is accepted behaviour.

## Structure
- Shared package `rv32i_types`: add `mem_arb_state_t` (enum `IDLE`, `SERVE_I`, `SERVE_D`) and `mem_arb_owner_t` (`ARB_I`, `ARB_D`).
- Sub-module `mem_arb_priority` (combinational):
  - Inputs: `i_pend`, `d_pend`, `last_grant`.
  - Outputs: `grant_valid`, `grant_owner`.
  - It holds the `MEM_ARB_ROUND_ROBIN_EN` variant.
- Request latch, FSM and response routing stay in `mem_arbiter`.

## Test plan
- Reset with inputs toggling: hold `rst` low → all outputs 0. Release it with `i_mem_read` at address 0x60 → `mem_read` rises 1 cycle later with `mem_address` = 0x60.
- Single fetch: `i_mem_read` at 0x100, memory answers `mem_rdata` = 0xDEADBEEF after 3 cycles → `i_mem_resp` pulses 1 cycle with rdata 0xDEADBEEF, `lsq_mem_resp` stays 0, and the FSM is in `IDLE` the next cycle.
- Contested grant, macro off: both ports raise reads in the same cycle → LSQ is served first, fetch second, and `mem_address` order is LSQ then fetch.
- Contested grant, macro on: three back-to-back contested rounds → grants go fetch, LSQ, fetch.
- LSQ write with `lsq_mem_byte_enable` = 4'b0011, wdata 0x1234ABCD, addr 0x2000:
  - Requester inputs change during the transaction → `mem_*` stays frozen until `mem_resp`.
  - `lsq_mem_resp` pulses.
- Asynchronous reset asserted mid-`SERVE_D` with the response outstanding → outputs clear immediately, and no `lsq_mem_resp` is produced even if `mem_resp` arrives later.
